// File: rtl/neo_fix_pkg.sv
// Shared types and S-ROM address layout for the NEO fix-layer tile fetcher.
// Word address is {bank, tile, line, half}; half selects pixels 0-3 or 4-7.
package neo_fix_pkg;

    localparam int SROM_AW  = 18;
    localparam int BANK_LSB = 16;
    localparam int TILE_LSB = 4;
    localparam int LINE_LSB = 1;

    typedef enum logic [1:0] {
        FIX_IDLE = 2'd0,
        FIX_RD0  = 2'd1,
        FIX_RD1  = 2'd2,
        FIX_DONE = 2'd3
    } FixState_e;

    typedef struct packed {
        logic [11:0] tile;
        logic [3:0]  pal;
        logic [1:0]  bank;
        logic [2:0]  line;
    } FixReq_t;

    function automatic logic [SROM_AW-1:0] fixWordAddr(
        input logic [1:0]  bank,
        input logic [11:0] tile,
        input logic [2:0]  line,
        input logic        half
    );
        logic [SROM_AW-1:0] addr;
        addr = (SROM_AW'(bank) << BANK_LSB)
             | (SROM_AW'(tile) << TILE_LSB)
             | (SROM_AW'(line) << LINE_LSB)
             | SROM_AW'(half);
        return addr;
    endfunction

endpackage

// File: rtl/neo_fix_pixbuf.sv
// Output buffer for one fix tile line: 8 nibbles, palette and a pixel counter.
// Reports ready when empty or when the last pixel leaves this cycle, so a refill has no gap.
module neo_fix_pixbuf
    import neo_fix_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [31:0] i_loadData,
    input  logic [3:0]  i_loadPal,
    input  logic        i_pixEn,
    output logic [7:0]  o_pixOut,
    output logic        o_pixValid,
    output logic        o_ready
);

    logic [31:0] r_data;
    logic [3:0]  r_pal;
    logic [2:0]  r_cnt;
    logic        r_valid;

    logic        w_lastPix;
    logic [3:0]  w_nibble;

    assign w_lastPix = r_valid && i_pixEn && (r_cnt == 3'd7);
    assign w_nibble  = r_data[{r_cnt, 2'b00} +: 4];

    // A load always wins over the wrap so the next tile follows without a transparent pixel.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data  <= '0;
            r_pal   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_loadData;
            r_pal   <= i_loadPal;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && i_pixEn) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_valid <= 1'b0;
            end
        end
    end

    // An empty buffer shows the last palette with colour 0, which the mixer treats as transparent.
    assign o_pixOut   = {r_pal, (r_valid ? w_nibble : 4'h0)};
    assign o_pixValid = r_valid;
    assign o_ready    = !r_valid || w_lastPix;

endmodule

// File: rtl/neo_fix_fetch.sv
// Fix-layer tile fetcher: latches fix map requests, reads two S-ROM words per tile line
// over a req/ack handshake and hands the 8 pixels to a double-buffered output stage.
module neo_fix_fetch
    import neo_fix_pkg::*;
#(
    parameter int AW = SROM_AW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_tileStb,
    input  logic [11:0]   i_tile,
    input  logic [3:0]    i_pal,
    input  logic [1:0]    i_bank,
    input  logic [2:0]    i_line,
    output logic [AW-1:0] o_sromAddr,
    output logic          o_sromRd,
    input  logic          i_sromAck,
    input  logic [15:0]   i_sromData,
    input  logic          i_pixEn,
    output logic [7:0]    o_pixOut,
    output logic          o_pixValid,
    output logic          o_overrun
);

    FixReq_t     r_req;
    logic        r_pending;
    logic        r_overrun;

    FixState_e   r_state;
    logic        r_sromRd;
    logic [AW-1:0] r_sromAddr;
    logic [31:0] r_fetch;
    logic [3:0]  r_fetchPal;

    logic        w_take;
    logic        w_bufReady;
    logic        w_load;
    logic [AW-1:0] w_addrH0;

    assign w_take   = (r_state == FIX_IDLE) && r_pending;
    assign w_load   = (r_state == FIX_DONE) && w_bufReady;
    assign w_addrH0 = AW'(fixWordAddr(r_req.bank, r_req.tile, r_req.line, 1'b0));

    // A strobe landing on the edge where the old request is taken is not an overrun.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_req     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_take) begin
                r_pending <= 1'b0;
            end
            if (i_tileStb) begin
                r_req.tile <= i_tile;
                r_req.pal  <= i_pal;
                r_req.bank <= i_bank;
                r_req.line <= i_line;
                r_pending  <= 1'b1;
                if (r_pending && !w_take) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // The fetch buffer is only busy from RD0 to DONE, so IDLE implies it is free.
    // The address is frozen at launch; only the half bit flips, so a later strobe cannot disturb it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= FIX_IDLE;
            r_sromRd   <= 1'b0;
            r_sromAddr <= '0;
            r_fetch    <= '0;
            r_fetchPal <= '0;
        end else begin
            unique case (r_state)
                FIX_IDLE: begin
                    if (r_pending) begin
                        r_sromAddr <= w_addrH0;
                        r_sromRd   <= 1'b1;
                        r_fetchPal <= r_req.pal;
                        r_state    <= FIX_RD0;
                    end
                end
                FIX_RD0: begin
                    if (i_sromAck) begin
                        r_fetch[15:0] <= i_sromData;
                        r_sromAddr[0] <= 1'b1;
                        r_state       <= FIX_RD1;
                    end
                end
                FIX_RD1: begin
                    if (i_sromAck) begin
                        r_fetch[31:16] <= i_sromData;
                        r_sromRd       <= 1'b0;
                        r_state        <= FIX_DONE;
                    end
                end
                FIX_DONE: begin
                    if (w_bufReady) begin
                        r_state <= FIX_IDLE;
                    end
                end
                default: begin
                    r_state  <= FIX_IDLE;
                    r_sromRd <= 1'b0;
                end
            endcase
        end
    end

    neo_fix_pixbuf u_pixbuf (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_loadData (r_fetch),
        .i_loadPal  (r_fetchPal),
        .i_pixEn    (i_pixEn),
        .o_pixOut   (o_pixOut),
        .o_pixValid (o_pixValid),
        .o_ready    (w_bufReady)
    );

    assign o_sromAddr = r_sromAddr;
    assign o_sromRd   = r_sromRd;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_neo_fix_fetch.sv
// Directed bench for neo_fix_fetch: latency, address layout, pixel order, back-to-back
// refill, overrun, stalled/stray acks, underflow and asynchronous reset mid-fetch.
module tb_neo_fix_fetch;

    logic        clk;
    logic        reset;
    logic        tileStb;
    logic [11:0] tile;
    logic [3:0]  pal;
    logic [1:0]  bank;
    logic [2:0]  line;
    logic [17:0] sromAddr;
    logic        sromRd;
    logic        sromAck;
    logic [15:0] sromData;
    logic        pixEn;
    logic [7:0]  pixOut;
    logic        pixValid;
    logic        overrun;

    int passCount = 0;
    int checkCount = 0;

    neo_fix_fetch #(.AW(18)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_tileStb  (tileStb),
        .i_tile     (tile),
        .i_pal      (pal),
        .i_bank     (bank),
        .i_line     (line),
        .o_sromAddr (sromAddr),
        .o_sromRd   (sromRd),
        .i_sromAck  (sromAck),
        .i_sromData (sromData),
        .i_pixEn    (pixEn),
        .o_pixOut   (pixOut),
        .o_pixValid (pixValid),
        .o_overrun  (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and settle; both driving and sampling happen 1ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [11:0] t, input logic [3:0] p,
                          input logic [1:0] b, input logic [2:0] l);
        tile = t; pal = p; bank = b; line = l;
        tileStb = 1'b1;
        tick();
        tileStb = 1'b0;
    endtask

    task automatic waitRd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32 && !ok; i++) begin
            if (sromRd) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic ackWord(input logic [15:0] d);
        sromAck = 1'b1;
        sromData = d;
        tick();
        sromAck = 1'b0;
        sromData = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checkCount++;
        if ({sromRd, sromAddr, pixOut, pixValid, overrun} !== 29'd0)
            $display("[TB] FAIL reset_outputs: got rd=%0b addr=%h pix=%h valid=%0b ovr=%0b, want all 0",
                     sromRd, sromAddr, pixOut, pixValid, overrun);
        else passCount++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_underflow();
        pixEn = 1'b1;
        tick();
        tick();
        checkCount++;
        if (pixOut !== 8'h00 || pixValid !== 1'b0)
            $display("[TB] FAIL underflow: got pix=%h valid=%0b, want pix=00 valid=0", pixOut, pixValid);
        else passCount++;
        pixEn = 1'b0;
    endtask

    task automatic test_single_tile();
        strobe(12'h123, 4'h5, 2'd2, 3'd3);
        checkCount++;
        if (sromRd !== 1'b0) $display("[TB] FAIL single_rd_cycle1: got %0b, want 0", sromRd);
        else passCount++;
        tick();
        checkCount++;
        if (sromRd !== 1'b1 || sromAddr !== 18'h21236)
            $display("[TB] FAIL single_rd_cycle2: got rd=%0b addr=%h, want rd=1 addr=21236", sromRd, sromAddr);
        else passCount++;
        tick();
        ackWord(16'h3210);
        checkCount++;
        if (sromRd !== 1'b1 || sromAddr !== 18'h21237)
            $display("[TB] FAIL single_addr_h1: got rd=%0b addr=%h, want rd=1 addr=21237", sromRd, sromAddr);
        else passCount++;
        ackWord(16'h7654);
        checkCount++;
        if (sromRd !== 1'b0 || pixValid !== 1'b0)
            $display("[TB] FAIL single_after_ack2: got rd=%0b valid=%0b, want rd=0 valid=0", sromRd, pixValid);
        else passCount++;
        tick();
        pixEn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (pixOut !== (8'h50 + 8'(i)) || pixValid !== 1'b1)
                $display("[TB] FAIL single_pix%0d: got pix=%h valid=%0b, want pix=%h valid=1",
                         i, pixOut, pixValid, 8'h50 + 8'(i));
            else passCount++;
            tick();
        end
        pixEn = 1'b0;
        checkCount++;
        if (pixOut !== 8'h50 || pixValid !== 1'b0)
            $display("[TB] FAIL single_drained: got pix=%h valid=%0b, want pix=50 valid=0", pixOut, pixValid);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        strobe(12'h0F0, 4'hA, 2'd3, 3'd7);
        waitRd(ok);
        checkCount++;
        if (!ok || sromAddr !== 18'h30F0E)
            $display("[TB] FAIL b2b_addrA: got ok=%0b addr=%h, want ok=1 addr=30f0e", ok, sromAddr);
        else passCount++;
        ackWord(16'h3210);
        ackWord(16'h7654);
        tile = 12'hABC; pal = 4'hC; bank = 2'd1; line = 3'd5;
        tileStb = 1'b1;
        tick();
        tileStb = 1'b0;
        waitRd(ok);
        checkCount++;
        if (!ok || sromAddr !== 18'h1ABCA)
            $display("[TB] FAIL b2b_addrB: got ok=%0b addr=%h, want ok=1 addr=1abca", ok, sromAddr);
        else passCount++;
        ackWord(16'hBA98);
        ackWord(16'hFEDC);
        tick();
        pixEn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp;
            exp = (i < 8) ? (8'hA0 + 8'(i)) : (8'hC0 + 8'(i));
            checkCount++;
            if (pixOut !== exp || pixValid !== 1'b1)
                $display("[TB] FAIL b2b_pix%0d: got pix=%h valid=%0b, want pix=%h valid=1",
                         i, pixOut, pixValid, exp);
            else passCount++;
            tick();
        end
        pixEn = 1'b0;
        checkCount++;
        if (pixValid !== 1'b0) $display("[TB] FAIL b2b_empty: got valid=%0b, want 0", pixValid);
        else passCount++;
    endtask

    task automatic test_overrun();
        bit ok;
        strobe(12'h111, 4'h1, 2'd0, 3'd1);
        waitRd(ok);
        strobe(12'h222, 4'h2, 2'd1, 3'd2);
        checkCount++;
        if (overrun !== 1'b0) $display("[TB] FAIL ovr_first: got %0b, want 0", overrun);
        else passCount++;
        tick();
        strobe(12'h333, 4'h3, 2'd2, 3'd4);
        checkCount++;
        if (overrun !== 1'b1 || sromAddr !== 18'h01112)
            $display("[TB] FAIL ovr_set: got ovr=%0b addr=%h, want ovr=1 addr=01112", overrun, sromAddr);
        else passCount++;
        ackWord(16'h0000);
        ackWord(16'h0000);
        tick();
        waitRd(ok);
        checkCount++;
        if (!ok || sromAddr !== 18'h23338)
            $display("[TB] FAIL ovr_next_addr: got ok=%0b addr=%h, want ok=1 addr=23338", ok, sromAddr);
        else passCount++;
        ackWord(16'h5555);
        ackWord(16'h5555);
        pixEn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                checkCount++;
                if (pixOut !== 8'h10) $display("[TB] FAIL ovr_pix_t1: got %h, want 10", pixOut);
                else passCount++;
            end
            if (i == 8) begin
                checkCount++;
                if (pixOut !== 8'h35) $display("[TB] FAIL ovr_pix_t3: got %h, want 35", pixOut);
                else passCount++;
            end
            tick();
        end
        pixEn = 1'b0;
        checkCount++;
        if (overrun !== 1'b1) $display("[TB] FAIL ovr_sticky: got %0b, want 1", overrun);
        else passCount++;
    endtask

    task automatic test_stalled_ack();
        bit ok;
        bit stable;
        logic [7:0] expPix [8];
        expPix = '{8'hE4, 8'hE3, 8'hE2, 8'hE1, 8'hE8, 8'hE7, 8'hE6, 8'hE5};
        strobe(12'hFFF, 4'hE, 2'd0, 3'd0);
        waitRd(ok);
        stable = ok;
        for (int i = 0; i < 20; i++) begin
            if (sromRd !== 1'b1 || sromAddr !== 18'h0FFF0) stable = 1'b0;
            tick();
        end
        checkCount++;
        if (!stable || sromAddr !== 18'h0FFF0)
            $display("[TB] FAIL stall_hold: got rd=%0b addr=%h, want rd=1 addr=0fff0 held", sromRd, sromAddr);
        else passCount++;
        ackWord(16'h1234);
        checkCount++;
        if (sromAddr !== 18'h0FFF1) $display("[TB] FAIL stall_addr_h1: got %h, want 0fff1", sromAddr);
        else passCount++;
        ackWord(16'h5678);
        tick();
        tick();
        ackWord(16'hDEAD);
        tick();
        checkCount++;
        if (sromRd !== 1'b0 || pixValid !== 1'b1 || pixOut !== 8'hE4)
            $display("[TB] FAIL stray_ack: got rd=%0b valid=%0b pix=%h, want rd=0 valid=1 pix=e4",
                     sromRd, pixValid, pixOut);
        else passCount++;
        pixEn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (pixOut !== expPix[i]) $display("[TB] FAIL stall_pix%0d: got %h, want %h", i, pixOut, expPix[i]);
            else passCount++;
            tick();
        end
        pixEn = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        strobe(12'h456, 4'h7, 2'd1, 3'd6);
        waitRd(ok);
        ackWord(16'h3210);
        checkCount++;
        if (sromRd !== 1'b1 || sromAddr !== 18'h1456D)
            $display("[TB] FAIL rst_mid_in_rd1: got rd=%0b addr=%h, want rd=1 addr=1456d", sromRd, sromAddr);
        else passCount++;
        #2;
        reset = 1'b1;
        #1;
        checkCount++;
        if ({sromRd, sromAddr, pixOut, pixValid, overrun} !== 29'd0)
            $display("[TB] FAIL rst_mid_async: got rd=%0b addr=%h pix=%h valid=%0b ovr=%0b, want all 0",
                     sromRd, sromAddr, pixOut, pixValid, overrun);
        else passCount++;
        tick();
        reset = 1'b0;
        tick();
        checkCount++;
        if (sromRd !== 1'b0) $display("[TB] FAIL rst_mid_idle: got rd=%0b, want 0", sromRd);
        else passCount++;
        strobe(12'h456, 4'h7, 2'd1, 3'd6);
        waitRd(ok);
        checkCount++;
        if (!ok || sromAddr !== 18'h1456C)
            $display("[TB] FAIL rst_mid_refetch: got ok=%0b addr=%h, want ok=1 addr=1456c", ok, sromAddr);
        else passCount++;
        ackWord(16'h3210);
        ackWord(16'h7654);
        tick();
        checkCount++;
        if (pixOut !== 8'h70 || pixValid !== 1'b1)
            $display("[TB] FAIL rst_mid_pix0: got pix=%h valid=%0b, want pix=70 valid=1", pixOut, pixValid);
        else passCount++;
    endtask

    initial begin
        reset = 1'b1;
        tileStb = 1'b0;
        tile = '0; pal = '0; bank = '0; line = '0;
        sromAck = 1'b0;
        sromData = '0;
        pixEn = 1'b0;
        #1;
        test_reset();
        test_underflow();
        test_single_tile();
        test_back_to_back();
        test_overrun();
        test_stalled_ack();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
